// File: rtl/adc_fb_pkg.sv
// adc_fb_pkg: shared types and constants for the adc-to-framebuffer scheduler
package adc_fb_pkg;
  typedef logic [2:0] color_t;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
  localparam color_t COLOR_BLANK = 3'b000;
endpackage

// File: rtl/fb_clear_gen.sv
// fb_clear_gen: full-screen clear sweep issuing one blank write request per pixel
// start: begin a sweep when idle; grant: arbiter took the pending request
// req/addr: pending clear write and its address; busy: sweep in progress
module fb_clear_gen
  import adc_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 19,
  parameter int NPIX = 640 * 480
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic grant,
  output logic req,
  output logic busy,
  output logic [ADDR_WIDTH-1:0] addr
);
  clr_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLR_IDLE;
      addr <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
    end
  always_comb begin
    state_n = state;
    addr_n = addr;
    if (state == CLR_IDLE) begin
      state_n = start ? CLR_RUN : CLR_IDLE;
      addr_n = '0;
    end else if (grant) begin
      state_n = (addr == ADDR_WIDTH'(NPIX - 1)) ? CLR_IDLE : CLR_RUN;
      addr_n = addr + ADDR_WIDTH'(1);
    end
  end
  assign req = state == CLR_RUN;
  assign busy = req;
endmodule

// File: rtl/adc_fb_sched.sv
// adc_fb_sched: schedules adc_xy points and a screen-clear sweep onto one framebuffer write port
// adc_*: sample stream in (valid/ready); clear_start/clear_busy: clear control
// fb_wr_*: write command out (valid/ready); drop_count: saturating out-of-range count
module adc_fb_sched
  import adc_fb_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int CLEAR_WEIGHT = 4,
  parameter int DEDUP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic adc_valid,
  output logic adc_ready,
  input  logic [DATA_WIDTH-1:0] adc_x,
  input  logic [DATA_WIDTH-1:0] adc_y,
  input  logic adc_red,
  input  logic adc_grn,
  input  logic adc_blu,
  input  logic clear_start,
  output logic clear_busy,
  output logic fb_wr_valid,
  input  logic fb_wr_ready,
  output logic [ADDR_WIDTH-1:0] fb_wr_addr,
  output color_t fb_wr_color,
  output logic [15:0] drop_count
);
  localparam int WW = $clog2(CLEAR_WEIGHT);
  logic hold_v, cache_v, clr_req, load_out, grant_clr, grant_pt, hs, oor, dup, keep;
  logic [ADDR_WIDTH-1:0] hold_addr, clr_addr;
  logic [DATA_WIDTH-1:0] hold_x, hold_y, cache_x, cache_y;
  color_t color, hold_color, cache_color;
  logic [WW-1:0] wcnt;
  fb_clear_gen #(.ADDR_WIDTH(ADDR_WIDTH), .NPIX(H_RES * V_RES)) u_clear (
    .clk(clk),
    .rst(rst),
    .start(clear_start),
    .grant(grant_clr),
    .req(clr_req),
    .busy(clear_busy),
    .addr(clr_addr)
  );
  assign color = {adc_red, adc_grn, adc_blu};
  assign load_out = !fb_wr_valid || fb_wr_ready;
  // clear wins a contended slot only on the last step of the weight cycle
  assign grant_clr = load_out && clr_req && (!hold_v || wcnt == WW'(CLEAR_WEIGHT - 1));
  assign grant_pt = load_out && hold_v && !grant_clr;
  // gated by rst so the handshake is closed while reset is asserted
  assign adc_ready = !rst && (!hold_v || grant_pt);
  assign hs = adc_valid && adc_ready;
  assign oor = 32'(adc_x) >= 32'(H_RES) || 32'(adc_y) >= 32'(V_RES);
  assign dup = DEDUP != 0 && cache_v && adc_x == cache_x && adc_y == cache_y && color == cache_color;
  assign keep = hs && !oor && color != COLOR_BLANK && !dup;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_v <= 1'b0;
      hold_addr <= '0;
      hold_x <= '0;
      hold_y <= '0;
      hold_color <= COLOR_BLANK;
      cache_v <= 1'b0;
      cache_x <= '0;
      cache_y <= '0;
      cache_color <= COLOR_BLANK;
      wcnt <= '0;
      drop_count <= '0;
      fb_wr_valid <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_color <= COLOR_BLANK;
    end else begin
      hold_v <= keep || (hold_v && !grant_pt);
      if (keep) begin
        hold_addr <= ADDR_WIDTH'(adc_y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(adc_x);
        hold_x <= adc_x;
        hold_y <= adc_y;
        hold_color <= color;
      end
      if (hs && oor && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      // a clear wipes what the cache remembers, so redraws must not be suppressed
      if (grant_pt) begin
        cache_v <= 1'b1;
        cache_x <= hold_x;
        cache_y <= hold_y;
        cache_color <= hold_color;
      end else if (grant_clr) cache_v <= 1'b0;
      wcnt <= grant_clr ? '0 : (grant_pt && clr_req) ? wcnt + WW'(1) : wcnt;
      if (load_out) fb_wr_valid <= grant_pt || grant_clr;
      if (grant_pt) begin
        fb_wr_addr <= hold_addr;
        fb_wr_color <= hold_color;
      end else if (grant_clr) begin
        fb_wr_addr <= clr_addr;
        fb_wr_color <= COLOR_BLANK;
      end
    end
endmodule

// File: tb/tb_adc_fb_sched.sv
// tb_adc_fb_sched: scoreboard bench for adc_fb_sched (640x480 instance and 8x4 clear instance)
module tb_adc_fb_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic av[2], ar[2], rd[2], gr[2], bl[2], cs[2], cb[2], wv[2], wr[2];
  logic [9:0] ax[2], ay[2];
  logic [18:0] wa[2];
  logic [2:0] wc[2];
  logic [15:0] dc[2];
  int n_cmp = 0, n_bad = 0;
  logic [21:0] mq[$], s_pt[$];
  logic [18:0] s_clr[$];
  int m_drop = 0, m_lx = 0, m_ly = 0;
  logic m_lv = 1'b0;
  logic [2:0] m_lc = 3'b000;
  int n_clr = 0, gap = 0;
  bit fired = 0, rnd_on = 0;
  logic [21:0] e;

  always #5 clk = ~clk;

  adc_fb_sched u_main (
    .clk(clk), .rst(rst), .adc_valid(av[0]), .adc_ready(ar[0]), .adc_x(ax[0]), .adc_y(ay[0]),
    .adc_red(rd[0]), .adc_grn(gr[0]), .adc_blu(bl[0]), .clear_start(cs[0]), .clear_busy(cb[0]),
    .fb_wr_valid(wv[0]), .fb_wr_ready(wr[0]), .fb_wr_addr(wa[0]), .fb_wr_color(wc[0]),
    .drop_count(dc[0])
  );

  adc_fb_sched #(.H_RES(8), .V_RES(4), .CLEAR_WEIGHT(4), .DEDUP(0)) u_small (
    .clk(clk), .rst(rst), .adc_valid(av[1]), .adc_ready(ar[1]), .adc_x(ax[1]), .adc_y(ay[1]),
    .adc_red(rd[1]), .adc_grn(gr[1]), .adc_blu(bl[1]), .clear_start(cs[1]), .clear_busy(cb[1]),
    .fb_wr_valid(wv[1]), .fb_wr_ready(wr[1]), .fb_wr_addr(wa[1]), .fb_wr_color(wc[1]),
    .drop_count(dc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: write presented, none expected", name);
  endtask

  // reference: what should reach the framebuffer for each accepted sample
  function automatic void model(input int d, input int x, input int y, input logic [2:0] c);
    if (d == 1) s_pt.push_back({19'(y * 8 + x), c});
    else if (x >= 640 || y >= 480) m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
    else if (c != 3'b000 && !(m_lv && x == m_lx && y == m_ly && c == m_lc)) begin
      mq.push_back({19'(y * 640 + x), c});
      m_lv = 1'b1;
      m_lx = x;
      m_ly = y;
      m_lc = c;
    end
  endfunction

  task automatic send(input int d, input int x, input int y, input logic [2:0] c, output int cyc);
    bit hs = 0;
    av[d] = 1'b1;
    ax[d] = 10'(x);
    ay[d] = 10'(y);
    {rd[d], gr[d], bl[d]} = c;
    cyc = 0;
    while (!hs && cyc < 300) begin
      @(negedge clk);
      hs = ar[d];
      @(posedge clk);
      cyc++;
    end
    chk("send_handshake", 32'(hs), 1);
    if (hs) model(d, x, y, c);
    #1 av[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t = 0;
    while ((d == 0 ? mq.size() : s_pt.size() + s_clr.size()) != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("drain", d == 0 ? mq.size() : s_pt.size() + s_clr.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (wv[0] && wr[0]) begin
        if (mq.size() == 0) flag("main_extra_write");
        else begin
          e = mq.pop_front();
          chk("main_write", {10'd0, wa[0], wc[0]}, {10'd0, e});
        end
      end
      if (wv[1] && wr[1]) begin
        if (wc[1] == 3'b000) begin
          n_clr++;
          if (s_clr.size() == 0) flag("clear_extra_write");
          else chk("clear_addr", 32'(wa[1]), 32'(s_clr.pop_front()));
          if (n_clr > 1) chk("clear_weight_gap", gap, 3);
          if (wa[1] == 19'd31) chk("clear_busy_fall", 32'(cb[1]), 0);
          gap = 0;
        end else begin
          gap++;
          if (s_pt.size() == 0) flag("small_extra_write");
          else begin
            e = s_pt.pop_front();
            chk("small_point", {10'd0, wa[1], wc[1]}, {10'd0, e});
          end
        end
      end
    end

  always @(posedge clk) if (rnd_on) #1 wr[0] = ($urandom_range(0, 3) != 0);

  initial begin
    #900000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: run did not complete, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int cy, tot, x, y, i;
    logic [2:0] c;
    for (int d = 0; d < 2; d++) begin
      av[d] = 0; ax[d] = 0; ay[d] = 0; rd[d] = 0; gr[d] = 0; bl[d] = 0; cs[d] = 0; wr[d] = 1;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(ar[d]), 0);
      chk("rst_valid", 32'(wv[d]), 0);
      chk("rst_busy", 32'(cb[d]), 0);
      chk("rst_drop", 32'(dc[d]), 0);
      chk("rst_addr", 32'(wa[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ar[0]), 1);
    chk("ready_after_reset_s", 32'(ar[1]), 1);
    @(posedge clk);
    #1;
    send(0, 100, 200, 3'b100, cy);
    chk("latency_not_early", 32'(wv[0]), 0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(wv[0]), 1);
    chk("addr_100_200", 32'(wa[0]), 128100);
    chk("color_red", 32'(wc[0]), 3'b100);
    drain(0);
    wr[0] = 1'b0;
    fork
      begin
        send(0, 1, 1, 3'b010, cy);
        send(0, 2, 2, 3'b010, cy);
        send(0, 3, 3, 3'b010, cy);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("stall_addr_a", 32'(wa[0]), 641);
        chk("stall_ready_a", 32'(ar[0]), 0);
        repeat (3) @(posedge clk);
        #2;
        chk("stall_addr_b", 32'(wa[0]), 641);
        chk("stall_valid", 32'(wv[0]), 1);
        chk("stall_ready_b", 32'(ar[0]), 0);
        wr[0] = 1'b1;
      end
    join
    drain(0);
    tot = 0;
    for (int k = 0; k < 40; k++) begin
      y = $urandom_range(0, 479);
      c = 3'($urandom_range(1, 7));
      send(0, 300 + k, y, c, cy);
      tot += cy;
    end
    chk("throughput_cycles", tot, 40);
    drain(0);
    send(0, 700, 10, 3'b100, cy);
    drain(0);
    chk("drop_oor", 32'(dc[0]), 32'(m_drop));
    send(0, 5, 5, 3'b001, cy);
    drain(0);
    send(0, 5, 5, 3'b001, cy);
    drain(0);
    send(0, 6, 6, 3'b000, cy);
    drain(0);
    chk("drop_blank", 32'(dc[0]), 32'(m_drop));
    send(0, 639, 479, 3'b111, cy);
    send(0, 640, 0, 3'b111, cy);
    send(0, 0, 480, 3'b111, cy);
    drain(0);
    chk("drop_edges", 32'(dc[0]), 32'(m_drop));
    rnd_on = 1;
    x = 0; y = 0; c = 3'b001;
    for (int k = 0; k < 150; k++) begin
      if (k == 0 || $urandom_range(0, 3) != 0) begin
        x = $urandom_range(0, 719);
        y = $urandom_range(0, 519);
        c = 3'($urandom_range(0, 7));
      end
      send(0, x, y, c, cy);
      drain(0);
    end
    rnd_on = 0;
    repeat (2) @(posedge clk);
    #2 wr[0] = 1'b1;
    chk("drop_random", 32'(dc[0]), 32'(m_drop));
    wr[1] = 1'b1;
    i = 0;
    fork
      while (i < 400 && !(fired && i > 20 && !cb[1])) begin
        send(1, i % 8, (i / 8) % 4, 3'(1 + i % 7), cy);
        i++;
      end
      begin
        repeat (5) @(posedge clk);
        #1 cs[1] = 1'b1;
        for (int a = 0; a < 32; a++) s_clr.push_back(19'(a));
        fired = 1;
        @(posedge clk);
        #1 cs[1] = 1'b0;
        repeat (40) @(posedge clk);
        #1 cs[1] = 1'b1;
        @(posedge clk);
        #1 cs[1] = 1'b0;
      end
    join
    drain(1);
    chk("clear_count", n_clr, 32);
    chk("clear_idle", 32'(cb[1]), 0);
    wr[1] = 1'b0;
    cs[1] = 1'b1;
    for (int a = 0; a < 32; a++) s_clr.push_back(19'(a));
    @(posedge clk);
    #1 cs[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(wv[1]), 1);
    chk("pre_reset_busy", 32'(cb[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'(cb[1]), 0);
    chk("async_valid", 32'(wv[1]), 0);
    chk("async_ready", 32'(ar[0]), 0);
    s_clr.delete();
    s_pt.delete();
    mq.delete();
    m_drop = 0;
    m_lv = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    wr[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_clear_after_reset", 32'(cb[1]), 0);
    chk("idle_after_reset", 32'(wv[1]), 0);
    chk("drop_after_reset", 32'(dc[0]), 32'(m_drop));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_fb_sched.md
Name: adc_fb_sched

Overview:
Scheduler between the adc_xy sample stream and the single framebuffer write port. It pulls scaled X/Y/RGB samples from adc_xy with a valid/ready handshake, converts them to linear framebuffer addresses and drops unusable samples. It shares the write port with a built-in screen-clear sweep, using a weighted grant so the clear always progresses. Sits in the clk domain directly after adc_xy and ahead of the framebuffer writer.

Parameters:
DATA_WIDTH, 10, width of adc_x/adc_y
H_RES, 640, visible columns; valid x is 0..H_RES-1
V_RES, 480, visible rows; valid y is 0..V_RES-1
ADDR_WIDTH, 19, framebuffer address width; must satisfy H_RES*V_RES <= 2**ADDR_WIDTH
CLEAR_WEIGHT, 4, when both requesters are pending, clear gets 1 of every CLEAR_WEIGHT grants; must be >= 2
DEDUP, 1, 1 = discard a point identical to the last point written

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
adc_valid  in  1  sample available from adc_xy
adc_ready  out  1  sample accepted when adc_valid & adc_ready
adc_x  in  DATA_WIDTH  scaled X
adc_y  in  DATA_WIDTH  scaled Y
adc_red  in  1  red
adc_grn  in  1  green
adc_blu  in  1  blue
clear_start  in  1  single-cycle pulse that starts a full-screen clear
clear_busy  out  1  clear sweep in progress
fb_wr_valid  out  1  write command valid
fb_wr_ready  in  1  framebuffer accepts the command
fb_wr_addr  out  ADDR_WIDTH  linear address, y*H_RES+x
fb_wr_color  out  3  {red,grn,blu}
drop_count  out  16  saturating count of out-of-range samples

Behaviour:
- One clock. Reset is asynchronous and active-high. While rst is high: adc_ready=0, fb_wr_valid=0, fb_wr_addr=0, fb_wr_color=0, clear_busy=0, drop_count=0, point holding register empty, dedup cache invalid, weight counter=0.
- Point stage (one-entry holding register):
  - adc_ready = holding register empty, or holding register being granted this cycle.
  - On a handshake, a sample with x>=H_RES or y>=V_RES is discarded and drop_count increments, saturating at 16'hFFFF.
  - A sample with color 000 (beam blank) is discarded without counting.
  - When DEDUP=1, a sample whose x, y and color all match the cache is discarded without counting.
  - Any other sample loads the holding register with addr=y*H_RES+x, computed as an unsigned multiply of width ADDR_WIDTH.
- Clear engine (fb_clear_gen) has states IDLE and RUN.
  - IDLE to RUN on clear_start; the clear address starts at 0. clear_busy=1 while in RUN.
  - In RUN it requests a write of color 000 at the clear address. The address increments on each accepted clear write.
  - RUN returns to IDLE when the write at address H_RES*V_RES-1 is accepted.
  - clear_start during RUN is ignored.
- Arbitration:
  - The output register is loaded when it is empty, or when fb_wr_valid & fb_wr_ready.
  - If only one requester is pending, that requester is granted.
  - If both are pending: grant clear when the weight counter is CLEAR_WEIGHT-1, otherwise grant point.
  - Weight counter: increments on a point grant while clear is pending; resets to 0 on a clear grant.
- Output handshake:
  - fb_wr_addr and fb_wr_color are held stable while fb_wr_valid=1 and fb_wr_ready=0.
  - fb_wr_valid never drops without a handshake.
- Dedup cache is updated with x, y and color when a point is granted. It is invalidated on every clear grant, so a point redrawn during or after a clear is always written.
- Latency and throughput:
  - A sample handshaken at edge N drives fb_wr_valid=1 after edge N+1, provided the point is granted at N+1.
  - Throughput is 1 point/cycle with fb_wr_ready=1 and no clear.

Decomposition:
- Shared package adc_fb_pkg:
  - color_t (3-bit {r,g,b})
  - clr_state_t {CLR_IDLE, CLR_RUN}
  - COLOR_BLANK=3'b000
- Sub-module fb_clear_gen: holds the clear FSM and address counter and exposes a req/addr/grant interface to the arbiter.
- Arbiter and point stage live in adc_fb_sched.

Test Plan:
1. Reset -> with rst high, check adc_ready=0, fb_wr_valid=0, clear_busy=0, drop_count=0. Check adc_ready=1 the first cycle after rst falls.
2. Send red point (100,200) with fb_wr_ready=1 -> fb_wr_addr=128100, fb_wr_color=3'b100, fb_wr_valid one cycle after the handshake.
3. Hold fb_wr_ready=0 and offer points (1,1), (2,2), (3,3) green -> first command is held stable and adc_ready deasserts once the holding register is full. After raising fb_wr_ready, addresses 641, 1282, 1923 are written in order with no loss.
4. Send (700,10) red -> no write and drop_count=1. Send (5,5) blue twice -> exactly one write at addr 3205. Send (6,6) with color 000 -> no write and drop_count still 1.
5. With H_RES=8, V_RES=4, CLEAR_WEIGHT=4, pulse clear_start during continuous distinct points -> clear writes take exactly every 4th grant. Exactly 32 clear writes (addr 0..31, color 000) occur and clear_busy falls after the last. A second clear_start mid-sweep has no effect.
6. Assert rst mid-clear with fb_wr_valid=1 -> clear_busy and fb_wr_valid go low without waiting for a clock edge. After release, no clear writes occur until a new clear_start.
